// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass, busy scoreboard
// and a post-reset sequencer that preloads sp/gp one register per cycle.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(32'h0001_0000),
  parameter logic [XLEN-1:0] GP_INIT = XLEN'(32'h0001_3418),
  localparam int AW = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready_o,
  input  logic [NWR-1:0]        we_i,
  input  logic [NWR*AW-1:0]     waddr_i,
  input  logic [NWR*XLEN-1:0]   wdata_i,
  input  logic [NRD*AW-1:0]     raddr_i,
  output logic [NRD*XLEN-1:0]   rdata_o,
  output logic [NRD-1:0]        rbusy_o,
  input  logic                  iss_v_i,
  input  logic [AW-1:0]         iss_rd_i,
  input  logic [AW-1:0]         dbg_addr_i,
  output logic [XLEN-1:0]       dbg_data_o
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];

  function automatic logic [XLEN-1:0] init_val(input logic [AW-1:0] idx);
    case (idx)
      AW'(2):  init_val = SP_INIT;
      AW'(3):  init_val = GP_INIT;
      default: init_val = {XLEN{1'b0}};
    endcase
  endfunction

  // Control state: reset restarts the init walk and drops every busy bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= INIT;
      idx_q   <= {AW{1'b0}};
      busy_q  <= {NREGS{1'b0}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  // Register contents; the init walk rewrites every entry after reset.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  // Next state: init walk, or port writes (ascending loop = highest port wins) and scoreboard.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    regs_d  = regs_q;
    case (state_q)
      INIT: begin
        regs_d[idx_q] = init_val(idx_q);
        idx_d         = idx_q + AW'(1);
        if (idx_q == AW'(NREGS - 1)) begin
          state_d = RUN;
        end else begin
          state_d = INIT;
        end
      end
      RUN: begin
        for (int k = 0; k < NWR; k++) begin
          regs_d[waddr_i[k*AW +: AW]] =
            (we_i[k] && (waddr_i[k*AW +: AW] != {AW{1'b0}})) ? wdata_i[k*XLEN +: XLEN]
                                                           : regs_d[waddr_i[k*AW +: AW]];
          busy_d[waddr_i[k*AW +: AW]] = we_i[k] ? 1'b0 : busy_d[waddr_i[k*AW +: AW]];
        end
        // A new producer issued alongside the old one's writeback keeps the register busy.
        busy_d[iss_rd_i] = (iss_v_i && (iss_rd_i != {AW{1'b0}})) ? 1'b1 : busy_d[iss_rd_i];
      end
      default: begin
        state_d = INIT;
        idx_d   = {AW{1'b0}};
      end
    endcase
  end

  assign ready_o = (state_q == RUN);

  // Read ports: registered value, optionally overridden by this cycle's write data.
  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    rdata_o = {(NRD*XLEN){1'b0}};
    rbusy_o = {NRD{1'b0}};
    ra      = {AW{1'b0}};
    rd      = {XLEN{1'b0}};
    for (int j = 0; j < NRD; j++) begin
      ra = raddr_i[j*AW +: AW];
      rd = regs_q[ra];
      for (int k = 0; k < NWR; k++) begin
        rd = ((BYPASS != 0) && we_i[k] && (waddr_i[k*AW +: AW] == ra)) ? wdata_i[k*XLEN +: XLEN] : rd;
      end
      if ((state_q == RUN) && (ra != {AW{1'b0}})) begin
        rdata_o[j*XLEN +: XLEN] = rd;
        rbusy_o[j]              = busy_q[ra];
      end else begin
        rdata_o[j*XLEN +: XLEN] = {XLEN{1'b0}};
        rbusy_o[j]              = 1'b0;
      end
    end
  end

  // Debug port sees registered state only.
  always_comb begin
    if (state_q == RUN) begin
      dbg_data_o = regs_q[dbg_addr_i];
    end else begin
      dbg_data_o = {XLEN{1'b0}};
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: default build (bypass on), a bypass-off twin, and a 16-reg/3-read/1-write build.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready_a, ready_b, ready_c;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata_a, rdata_b;
  logic [1:0]  rbusy_a, rbusy_b;
  logic        iss_v;
  logic [4:0]  iss_rd;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_a, dbg_b;

  logic        we_c;
  logic [3:0]  waddr_c;
  logic [31:0] wdata_c;
  logic [11:0] raddr_c;
  logic [95:0] rdata_c;
  logic [2:0]  rbusy_c;
  logic        iss_v_c;
  logic [3:0]  iss_rd_c;
  logic [3:0]  dbg_addr_c;
  logic [31:0] dbg_c;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_mp u_a (
    .clk(clk), .rst(rst), .ready_o(ready_a), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr), .rdata_o(rdata_a), .rbusy_o(rbusy_a), .iss_v_i(iss_v), .iss_rd_i(iss_rd),
    .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_a));

  regfile_mp #(.BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .ready_o(ready_b), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr), .rdata_o(rdata_b), .rbusy_o(rbusy_b), .iss_v_i(iss_v), .iss_rd_i(iss_rd),
    .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_b));

  regfile_mp #(.NREGS(16), .NRD(3), .NWR(1)) u_c (
    .clk(clk), .rst(rst), .ready_o(ready_c), .we_i(we_c), .waddr_i(waddr_c), .wdata_i(wdata_c),
    .raddr_i(raddr_c), .rdata_o(rdata_c), .rbusy_o(rbusy_c), .iss_v_i(iss_v_c), .iss_rd_i(iss_rd_c),
    .dbg_addr_i(dbg_addr_c), .dbg_data_o(dbg_c));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b0; we = 2'b00; waddr = 10'd0; wdata = 64'd0; raddr = 10'd0;
    iss_v = 1'b0; iss_rd = 5'd0; dbg_addr = 5'd2;
    we_c = 1'b0; waddr_c = 4'd0; wdata_c = 32'd0; iss_v_c = 1'b0; iss_rd_c = 4'd0;
    dbg_addr_c = 4'd0; raddr_c = {4'd0, 4'd3, 4'd2};
    tick(); tick();
    check_eq("reset_ready", {31'd0, ready_a}, 32'd0);
    check_eq("reset_busy", {30'd0, rbusy_a}, 32'd0);

    // Initial walk: x2 on read port 0 and debug.
    rst = 1'b1; raddr = {5'd0, 5'd2};
    for (int e = 1; e <= 32; e++) begin
      tick();
      if (e == 10) begin
        check_eq("init_rdata_zero", rdata_a[31:0], 32'd0);
        check_eq("init_dbg_zero", dbg_a, 32'd0);
      end
      if (e == 15) check_eq("c_ready_e15", {31'd0, ready_c}, 32'd0);
      if (e == 16) begin
        check_eq("c_ready_e16", {31'd0, ready_c}, 32'd1);
        check_eq("c_rd0_x2", rdata_c[31:0], 32'h0001_0000);
        check_eq("c_rd1_x3", rdata_c[63:32], 32'h0001_3418);
        check_eq("c_rd2_x0", rdata_c[95:64], 32'd0);
      end
      if (e == 31) check_eq("a_ready_e31", {31'd0, ready_a}, 32'd0);
    end
    check_eq("a_ready_e32", {31'd0, ready_a}, 32'd1);
    check_eq("dbg_x2", dbg_a, 32'h0001_0000);
    dbg_addr = 5'd3; settle();
    check_eq("dbg_x3", dbg_a, 32'h0001_3418);
    dbg_addr = 5'd5; settle();
    check_eq("dbg_x5", dbg_a, 32'd0);

    // Bypass vs. no-bypass on a fresh write.
    we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'd0, 32'hDEAD_BEEF}; raddr = {5'd0, 5'd5};
    settle();
    check_eq("byp_same_cycle", rdata_a[31:0], 32'hDEAD_BEEF);
    check_eq("nobyp_same_cycle", rdata_b[31:0], 32'd0);
    check_eq("dbg_never_bypassed", dbg_a, 32'd0);
    tick(); we = 2'b00; settle();
    check_eq("nobyp_next_cycle", rdata_b[31:0], 32'hDEAD_BEEF);
    check_eq("byp_next_cycle", rdata_a[31:0], 32'hDEAD_BEEF);

    // Two ports on x7: port 1 wins.
    we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h22, 32'h11}; raddr = {5'd0, 5'd7};
    settle();
    check_eq("byp_conflict", rdata_a[31:0], 32'h22);
    tick(); we = 2'b00; dbg_addr = 5'd7; settle();
    check_eq("conflict_a", rdata_a[31:0], 32'h22);
    check_eq("conflict_b", dbg_b, 32'h22);

    // Writes to x0 are dropped.
    we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'd0, 32'h55}; raddr = {5'd0, 5'd0};
    settle();
    check_eq("x0_byp", rdata_a[31:0], 32'd0);
    tick(); we = 2'b00; dbg_addr = 5'd0; settle();
    check_eq("x0_read", rdata_a[31:0], 32'd0);
    check_eq("x0_dbg", dbg_a, 32'd0);

    // Scoreboard on x9 via read port 1.
    raddr = {5'd9, 5'd0}; iss_v = 1'b1; iss_rd = 5'd9; settle();
    check_eq("busy_no_bypass", {31'd0, rbusy_a[1]}, 32'd0);
    tick(); iss_v = 1'b0; settle();
    check_eq("busy_after_issue", {31'd0, rbusy_a[1]}, 32'd1);
    we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'd0, 32'h1}; settle();
    check_eq("busy_until_edge", {31'd0, rbusy_a[1]}, 32'd1);
    tick(); we = 2'b00; settle();
    check_eq("busy_cleared", {31'd0, rbusy_a[1]}, 32'd0);
    iss_v = 1'b1; iss_rd = 5'd9; we = 2'b10; waddr = {5'd9, 5'd0}; wdata = {32'h2, 32'd0};
    tick(); iss_v = 1'b0; we = 2'b00; settle();
    check_eq("busy_set_wins", {31'd0, rbusy_a[1]}, 32'd1);
    check_eq("busy_set_wins_b", {31'd0, rbusy_b[1]}, 32'd1);
    check_eq("x9_written", rdata_a[63:32], 32'h2);

    // Reset in RUN with x9 busy, then again mid-init at idx 10.
    rst = 1'b0; tick(); rst = 1'b1; settle();
    check_eq("run_rst_ready", {31'd0, ready_a}, 32'd0);
    check_eq("run_rst_rdata", rdata_a[63:32], 32'd0);
    for (int e = 1; e <= 10; e++) tick();
    rst = 1'b0; tick(); rst = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      tick();
      if (e == 31) check_eq("rerun_ready_e31", {31'd0, ready_a}, 32'd0);
    end
    check_eq("rerun_ready_e32", {31'd0, ready_a}, 32'd1);
    check_eq("rerun_busy_clear", {31'd0, rbusy_a[1]}, 32'd0);
    check_eq("rerun_x9_zero", rdata_a[63:32], 32'd0);
    dbg_addr = 5'd7; settle();
    check_eq("rerun_x7_zero", dbg_a, 32'd0);
    dbg_addr = 5'd2; settle();
    check_eq("rerun_x2", dbg_a, 32'h0001_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the five-stage core, replacing the fixed 2-read/1-write file. It adds configurable read/write port counts, optional same-cycle write-to-read bypass, a per-register busy scoreboard for hazard detection, and a sequential post-reset initialisation sequencer that preloads sp/gp. It sits between decode (reads, issue) and writeback (writes, scoreboard clear).

## Interface
Parameters:
- XLEN, 32, data width
- NREGS, 32, register count (power of two, ≥4); AW = $clog2(NREGS)
- NRD, 2, read ports
- NWR, 2, write ports
- BYPASS, 1, 1 = same-cycle write data forwarded to reads
- SP_INIT, 32'h10000, reset value of x2
- GP_INIT, 32'h13418, reset value of x3

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- ready_o  out  1  high once init sequence done
- we_i  in  NWR  per-port write enable
- waddr_i  in  NWR*AW  packed write addresses, port k at [k*AW +: AW]
- wdata_i  in  NWR*XLEN  packed write data
- raddr_i  in  NRD*AW  packed read addresses
- rdata_o  out  NRD*XLEN  packed read data (combinational)
- rbusy_o  out  NRD  busy bit of each read address
- iss_v_i  in  1  issue: mark iss_rd_i busy
- iss_rd_i  in  AW  destination being issued
- dbg_addr_i  in  AW  debug read address
- dbg_data_o  out  XLEN  debug read data, never bypassed

## Operation
- FSM states INIT, RUN. rst low at a clk edge → INIT, init index idx=0, all busy bits 0, ready_o=0.
- INIT: each edge with rst high writes regs[idx] = SP_INIT if idx==2, GP_INIT if idx==3, else 0; idx++. Edge writing idx=NREGS-1 → RUN, ready_o=1 from then on.
- During INIT: we_i and iss_v_i ignored; rdata_o, rbusy_o, dbg_data_o all 0.
- RUN writes: port k writes regs[waddr_k] ← wdata_k when we_i[k] and waddr_k≠0. x0 reads 0 always.
- Two ports to same address, same cycle: highest-index port wins.
- Reads: rdata_o[j] = regs[raddr_j]; if BYPASS=1 and an enabled write port targets raddr_j (≠0) this cycle, return its data (highest-index port on conflict). BYPASS=0: old value until after the edge.
- Scoreboard: any enabled write to address a clears busy[a]; iss_v_i sets busy[iss_rd_i] (x0 never set). Same-cycle issue and write to the same register: set wins (new producer). rbusy_o[j] = busy[raddr_j], registered state only, no bypass of that cycle's issue/clear.
- rst low in RUN or mid-INIT: restart INIT from idx=0, busy cleared, ready_o 0 next cycle.

## Timing
- Reset values: ready_o=0, all busy=0; rdata_o/rbusy_o/dbg_data_o=0 until ready_o=1.
- ready_o rises after exactly NREGS clk edges with rst high following reset.
- Write latency 1 edge (0 for bypassed reads). Scoreboard update 1 edge.
- All read outputs are combinational from addresses and registered state.

## Test plan
- Reset, hold rst high 32 edges → ready_o rises on edge 32; dbg reads x2=0x10000, x3=0x13418, x5=0; reads during init return 0.
- RUN, we[0] to x5=0xDEADBEEF, raddr0=x5 same cycle → BYPASS=1: 0xDEADBEEF same cycle; BYPASS=0: old 0, new value next cycle.
- Both write ports to x7 (0x11, 0x22) same cycle → x7=0x22; write of 0x55 to x0 → x0 reads 0.
- Issue x9 → rbusy=1 next cycle; write x9 → rbusy=0 next cycle; issue+write x9 same cycle → busy stays 1.
- Pull rst low at idx=10 mid-INIT and again in RUN with busy bits set → idx restarts, busy cleared, ready_o after 32 more edges.
- NREGS=16, NRD=3, NWR=1 build: 16-cycle init, three independent reads of x2/x3/x0 return 0x10000/0x13418/0.
